// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader.
//   INSN_W        : instruction word width
//   HALT_OPCODE   : opcode field of the program terminator
//   HALT_WORD_DEF : full terminator word (HALT opcode, all other fields zero)
//   LD_*          : loader state encoding, also used as the enum values
package imem_loader_pkg;

    localparam int unsigned INSN_W = 32;

    localparam logic [5:0]        HALT_OPCODE   = 6'b111111;
    localparam logic [INSN_W-1:0] HALT_WORD_DEF = {HALT_OPCODE, 26'd0};

    localparam logic [1:0] LD_IDLE  = 2'd0;
    localparam logic [1:0] LD_LOAD  = 2'd1;
    localparam logic [1:0] LD_DONE  = 2'd2;
    localparam logic [1:0] LD_ERROR = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = LD_IDLE,
        StLoad  = LD_LOAD,
        StDone  = LD_DONE,
        StError = LD_ERROR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into big-endian 32-bit words.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   clear_i       : drop any partially assembled word and restart at byte 0
//   valid_i       : data_i carries a byte this cycle
//   data_i        : received byte
//   word_o        : last completed word (registered)
//   word_valid_o  : one-cycle pulse the cycle after the completing byte
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [7:0]        data_i,
    output logic [INSN_W-1:0] word_o,
    output logic              word_valid_o
);

    // Only the first three bytes need holding; the fourth goes straight into word_q.
    logic [23:0]       shift_q, shift_d;
    logic [1:0]        count_q, count_d;
    logic [INSN_W-1:0] word_q, word_d;
    logic              word_valid_q, word_valid_d;

    always_comb begin
        shift_d      = shift_q;
        count_d      = count_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear_i) begin
            shift_d = '0;
            count_d = '0;
        end else if (valid_i) begin
            shift_d = {shift_q[15:0], data_i};
            count_d = count_q + 2'd1;
            if (count_q == 2'd3) begin
                word_d       = {shift_q, data_i};
                word_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q      <= '0;
            count_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            count_q      <= count_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;

endmodule

// File: rtl/imem_loader.sv
// Program loader: packs received bytes into words, writes them sequentially
// into instruction memory and holds the CPU until the HALT word is written.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   i_start        : one-cycle request to begin a new load
//   i_rx_data/valid: received byte stream
//   o_imem_we      : one-cycle write strobe per completed word
//   o_imem_addr    : byte address (word index * 4)
//   o_imem_wdata   : word being written
//   o_cpu_hold     : halts fetch; low only after a successful load
//   o_busy         : load in progress
//   o_done/o_error : sticky outcome of the last load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       IMEM_DEPTH = 256,
    parameter logic [INSN_W-1:0] HALT_WORD  = HALT_WORD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_imem_we,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_imem_wdata,
    output logic        o_cpu_hold,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    localparam int unsigned      IDX_W    = $clog2(IMEM_DEPTH);
    localparam int unsigned      PAD_W    = 32 - IDX_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMEM_DEPTH - 1);

    loader_state_t     state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic              busy_q, busy_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              pack_clear;
    logic              rx_accept;
    logic [INSN_W-1:0] word;
    logic              word_valid;

    // Bytes are only taken while loading; a byte coincident with i_start is dropped.
    assign rx_accept = i_rx_valid && (state_q == StLoad);

    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (pack_clear),
        .valid_i      (rx_accept),
        .data_i       (i_rx_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        done_d     = done_q;
        error_d    = error_q;
        pack_clear = 1'b0;

        case (state_q)
            StLoad: begin
                // word_valid marks the write cycle; decide termination at its end.
                if (word_valid) begin
                    index_d = index_q + 1'b1;
                    if (word == HALT_WORD) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else if (index_q == LAST_IDX) begin
                        state_d = StError;
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                if (i_start) begin
                    state_d    = StLoad;
                    index_d    = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    pack_clear = 1'b1;
                end
            end
        endcase

        busy_d = (state_d == StLoad);
        hold_d = (state_d != StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            index_q <= '0;
            busy_q  <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Index advances only after the write cycle, so it is the current word's address.
    assign o_imem_we    = word_valid;
    assign o_imem_addr  = {{PAD_W{1'b0}}, index_q, 2'b00};
    assign o_imem_wdata = word;
    assign o_cpu_hold   = hold_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] HALT  = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_imem_we;
    logic [31:0] o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic        o_cpu_hold;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    imem_loader #(
        .IMEM_DEPTH (DEPTH),
        .HALT_WORD  (HALT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_cpu_hold   (o_cpu_hold),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] tx[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    logic       exp_done = 1'b0;
    logic       exp_error = 1'b0;
    logic       exp_busy = 1'b0;
    logic       prev_we  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endfunction

    // Monitor: every write strobe is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            prev_we = 1'b0;
        end else begin
            if (o_imem_we) begin
                check("we_single_cycle", {31'd0, prev_we}, 32'd0);
                check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", o_imem_addr, e.addr);
                    check("write_data", o_imem_wdata, e.data);
                    check("write_latency", cyc, e.cyc);
                end
            end
            prev_we = o_imem_we;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        tx.push_back(w[31:24]);
        tx.push_back(w[23:16]);
        tx.push_back(w[15:8]);
        tx.push_back(w[7:0]);
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        check({tag, "_we"},    {31'd0, o_imem_we},  32'd0);
        check({tag, "_busy"},  {31'd0, o_busy},     32'd0);
        check({tag, "_done"},  {31'd0, o_done},     32'd0);
        check({tag, "_error"}, {31'd0, o_error},    32'd0);
        check({tag, "_hold"},  {31'd0, o_cpu_hold}, 32'd1);
        check({tag, "_addr"},  o_imem_addr,         32'd0);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        i_start    = 1'b0;
        i_rx_valid = 1'b0;
        exp_q.delete();
        exp_done   = 1'b0;
        exp_error  = 1'b0;
        exp_busy   = 1'b0;
        check_reset_values("in_reset");
        tick();
        reset = 1'b0;
        check_reset_values("after_reset");
    endtask

    // Pulse i_start (optionally with a coincident byte that must be dropped).
    task automatic start_load(input bit junk);
        i_start = 1'b1;
        if (junk) begin
            i_rx_valid = 1'b1;
            i_rx_data  = 8'hA5;
        end
        tick();
        i_start    = 1'b0;
        i_rx_valid = 1'b0;
        @(negedge clk);
        check("start_busy",  {31'd0, o_busy},     32'd1);
        check("start_hold",  {31'd0, o_cpu_hold}, 32'd1);
        check("start_done",  {31'd0, o_done},     32'd0);
        check("start_error", {31'd0, o_error},    32'd0);
    endtask

    // Reference model: whole words are written in order until HALT or memory full.
    task automatic run_load(input int max_gap);
        logic [31:0] mw[$];
        int          n_wr;
        bit          term;
        n_wr = 0;
        term = 1'b0;
        exp_done  = 1'b0;
        exp_error = 1'b0;
        exp_busy  = 1'b1;
        for (int w = 0; w < tx.size() / 4 && !term; w++) begin
            logic [31:0] word;
            word = {tx[4*w], tx[4*w+1], tx[4*w+2], tx[4*w+3]};
            mw.push_back(word);
            n_wr++;
            if (word == HALT) begin
                exp_done = 1'b1;
                exp_busy = 1'b0;
                term     = 1'b1;
            end else if (w == DEPTH - 1) begin
                exp_error = 1'b1;
                exp_busy  = 1'b0;
                term      = 1'b1;
            end
        end
        for (int j = 0; j < tx.size(); j++) begin
            i_rx_data  = tx[j];
            i_rx_valid = 1'b1;
            if (j % 4 == 3 && j / 4 < n_wr)
                exp_q.push_back('{addr: 32'(j / 4) * 32'd4, data: mw[j / 4], cyc: cyc + 1});
            tick();
            i_rx_valid = 1'b0;
            i_rx_data  = 8'($urandom);
            repeat ($urandom_range(max_gap, 0)) tick();
        end
        tx.delete();
    endtask

    task automatic drain_and_status(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check({tag, "_drained"}, exp_q.size(), 32'd0);
        tick();
        tick();
        @(negedge clk);
        check({tag, "_busy"},  {31'd0, o_busy},     {31'd0, exp_busy});
        check({tag, "_done"},  {31'd0, o_done},     {31'd0, exp_done});
        check({tag, "_error"}, {31'd0, o_error},    {31'd0, exp_error});
        check({tag, "_hold"},  {31'd0, o_cpu_hold}, {31'd0, !exp_done});
    endtask

    task automatic push_prog3();
        push_word(32'h2001_0005);
        push_word(32'h2002_0007);
        push_word(HALT);
    endtask

    initial begin
        reset      = 1'b1;
        i_start    = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        do_reset();

        // Back-to-back bytes; coincident byte on i_start is dropped.
        start_load(1'b1);
        push_prog3();
        run_load(0);
        drain_and_status("prog_dense");

        // Sparse bytes (exactly 3 idle cycles) after restarting from DONE.
        start_load(1'b0);
        push_prog3();
        for (int j = 0; j < tx.size(); j++) begin
            logic [7:0] b;
            b = tx[j];
            i_rx_data  = b;
            i_rx_valid = 1'b1;
            if (j % 4 == 3)
                exp_q.push_back('{addr: 32'(j / 4) * 32'd4,
                                  data: {tx[j-3], tx[j-2], tx[j-1], b}, cyc: cyc + 1});
            tick();
            i_rx_valid = 1'b0;
            repeat (3) tick();
        end
        tx.delete();
        exp_done = 1'b1;
        exp_busy = 1'b0;
        drain_and_status("prog_sparse");

        // Restart from DONE: hold low until the start edge, then a single HALT write.
        @(negedge clk);
        check("pre_restart_hold", {31'd0, o_cpu_hold}, 32'd0);
        check("pre_restart_done", {31'd0, o_done},     32'd1);
        tick();
        start_load(1'b0);
        push_word(HALT);
        run_load(1);
        drain_and_status("halt_only");

        // Overflow: DEPTH non-halt words.
        start_load(1'b0);
        for (int w = 0; w < DEPTH; w++) push_word(32'h2000_0100 + 32'(w));
        run_load(2);
        drain_and_status("overflow");

        // Reset after 6 bytes aborts; later bytes are ignored; reload starts at 0.
        do_reset();
        start_load(1'b0);
        push_word(32'h1234_5678);
        tx.push_back(8'h9A);
        tx.push_back(8'hBC);
        run_load(0);
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) tick();
        do_reset();
        for (int j = 0; j < 8; j++) begin
            i_rx_data  = 8'(j);
            i_rx_valid = 1'b1;
            tick();
        end
        i_rx_valid = 1'b0;
        drain_and_status("aborted");
        start_load(1'b0);
        push_prog3();
        run_load(1);
        drain_and_status("reload");

        // Partial word left pending: one write, still busy.
        start_load(1'b0);
        push_word(32'hDEAD_BEEF);
        tx.push_back(8'h11);
        run_load(0);
        drain_and_status("partial");

        // Randomized loads.
        for (int it = 0; it < 30; it++) begin
            int nw;
            int halt_at;
            if (exp_busy) do_reset();
            start_load(1'($urandom));
            nw      = $urandom_range(5, 1);
            halt_at = $urandom_range(6, 0);
            for (int w = 0; w < nw; w++) begin
                logic [31:0] v;
                v = $urandom;
                if (v == HALT) v = v ^ 32'd1;
                if (w == halt_at) v = HALT;
                push_word(v);
            end
            repeat ($urandom_range(3, 0)) tx.push_back(8'($urandom));
            run_load(int'($urandom_range(3, 0)));
            drain_and_status("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
